lcd8080_stream_ctrl: RTL
========================

# lcd8080_stream_ctrl

Parametrised 8080-style parallel write controller for ILI934x-class TFT panels, supporting an 8- or 16-bit data bus. It accepts host requests through a valid/ready queue: command byte, parameter byte, single pixel, hardware rectangle fill (one RGB565 word repeated N times) and timed delay. The block performs the panel hardware-reset pulse itself after `rst_n`, then drains the queue onto the panel pins with programmable WR timing. It sits between the display sequencer/frame logic and the LCD pads.

## Interface
- `BUS_W`, 8, LCD data bus width; legal values 8 or 16 only.
- `FIFO_DEPTH`, 16, request queue depth; power of two, ≥2.
- `WR_LOW_CYC`, 2, WR low width in clk cycles, ≥1.
- `WR_HIGH_CYC`, 1, WR high/recovery cycles after each beat, ≥1.
- `RST_LOW_CYC`, 500, `lcd_rst_n` low time after reset release, ≥1.
- `RST_WAIT_CYC`, 6_000_000, wait after `lcd_rst_n` rises before the first bus beat, ≥1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on `req_valid && req_ready`.
- `req_op`  in  3  0=CMD, 1=DAT8, 2=PIX, 3=FILL, 4=DELAY, 5–7 illegal.
- `req_data`  in  16  byte in [7:0] (CMD/DAT8), RGB565 word (PIX/FILL).
- `req_count`  in  24  FILL pixel count or DELAY cycle count.
- `hw_ready`  out  1  panel reset sequence complete.
- `busy`  out  1  queue non-empty or engine not idle.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- `err_illegal`  out  1  one-cycle pulse when an illegal op is popped.
- `lcd_cs_n`, `lcd_rd_n`, `lcd_rst_n`, `lcd_dc`, `lcd_wr_n`  out  1 each  panel control (`lcd_dc`: 0=cmd, 1=data).
- `lcd_d`  out  BUS_W  panel data bus.

## Operation
- Reset values: `req_ready`=0, `hw_ready`=0, `busy`=1, `fifo_level`=0, `err_illegal`=0, `lcd_cs_n`=1, `lcd_rd_n`=1, `lcd_rst_n`=0, `lcd_dc`=0, `lcd_wr_n`=1, `lcd_d`=0. `lcd_rd_n` is constantly 1.
- `req_ready` = !full, evaluated on the registered level. A push while full is refused even if a pop occurs in the same cycle. Requests can be queued during the reset sequence.
- FSM: RST_LOW → RST_WAIT → IDLE ⇄ SETUP → WRLOW → WRHIGH, plus DLY.
  - RST_LOW holds `lcd_rst_n`=0 for RST_LOW_CYC cycles.
  - RST_WAIT counts RST_WAIT_CYC cycles with `lcd_rst_n`=1, then sets `hw_ready`=1, which stays 1 until reset.
  - IDLE pops the queue head when it is non-empty and decodes the op.
- Beat: SETUP drives `lcd_d`/`lcd_dc` and asserts `lcd_cs_n`=0 with `lcd_wr_n`=1. WRLOW holds `lcd_wr_n`=0 for WR_LOW_CYC cycles. WRHIGH holds `lcd_wr_n`=1 for WR_HIGH_CYC cycles. Data and DC are stable through the whole beat.
- Op behaviour:
  - CMD: 1 beat, `lcd_dc`=0, `lcd_d`[7:0]=byte; upper bits are 0 when BUS_W=16.
  - DAT8: same as CMD with `lcd_dc`=1.
  - PIX: BUS_W=16 is 1 beat with the full word. BUS_W=8 is 2 beats, [15:8] then [7:0].
  - FILL: PIX beats repeated `req_count` times; the 24-bit down-counter is latched at pop. Count 0 is consumed with no beats.
  - DELAY: DLY state for `req_count` cycles with no bus activity. Count 0 is consumed in the pop cycle only.
  - Illegal op: consumed, no bus activity, `err_illegal` pulses in the pop cycle.
- `lcd_cs_n` returns to 1 in the first IDLE cycle with an empty queue. It is held 0 across back-to-back beats and across DLY.
- Reset asserted mid-operation aborts immediately to reset values, flushes the queue and re-runs the panel reset sequence.

## Timing
- Beat period = 1 + WR_LOW_CYC + WR_HIGH_CYC cycles; 4 at defaults.
- Queue-to-bus latency: 1 cycle from push to visible entry, 1 IDLE pop cycle, then SETUP. The first `lcd_wr_n` fall occurs 3 cycles after the accepting edge.
- Successive requests: WRHIGH last cycle → IDLE pop → SETUP, giving a 1-cycle gap between requests. There is no gap between beats inside PIX/FILL.
- FILL at BUS_W=8, N pixels, defaults: 8·N bus cycles + 1 pop cycle.
- `busy`=0 only in IDLE with an empty queue and `hw_ready`=1.

## Structure
- Package `lcd8080_pkg` holds:
  - `lcd_op_e` (3-bit op enum);
  - `lcd_req_t` packed struct {op, data[15:0], count[23:0]};
  - FSM state enum;
  - localparam beats-per-pixel = 16/BUS_W.
- Sub-module `lcd_req_fifo`: synchronous FIFO of `lcd_req_t` with full/empty/level, parameterised by FIFO_DEPTH, pointer width $clog2+1 with wrap bit.
- The top level contains the reset sequencer, op decoder, beat FSM and counters.

## Test plan
- Reset and sequencing, RST_LOW_CYC=4, RST_WAIT_CYC=10: `lcd_rst_n` is low 4 cycles after `rst_n` rises; `hw_ready` rises 10 cycles later; no WR activity before that.
- Command and parameter, BUS_W=8: push CMD 0x2A then DAT8 0x00, 0xEF → 3 WR falls, `lcd_dc` 0,1,1, bytes 2A,00,EF, 1-cycle gap between beats.
- PIX width check: PIX 0xF81F gives bytes F8 then 1F when BUS_W=8, and a single beat F81F when BUS_W=16.
- FILL: count 5, word 0x07E0, BUS_W=8 → exactly 10 beats alternating 07/E0 with `lcd_cs_n` low throughout. Count 0 → no beats.
- Back-pressure and illegal op:
  - Fill the queue with FIFO_DEPTH=4 before `hw_ready`: `req_ready`=0 after 4 pushes and `fifo_level`=4.
  - An op 7 entry gives `err_illegal` 1-cycle pulse and no beat.
- Mid-FILL reset: assert `rst_n`=0 during FILL count 1000 → outputs return to reset values immediately, `fifo_level`=0, and the reset sequence restarts.

Source files
------------

// File: rtl/lcd8080_pkg.sv
// Shared types for the 8080-style LCD write controller: request format,
// op codes and engine states.
package lcd8080_pkg;

    typedef enum logic [2:0] {
        OP_CMD   = 3'd0,
        OP_DAT8  = 3'd1,
        OP_PIX   = 3'd2,
        OP_FILL  = 3'd3,
        OP_DELAY = 3'd4
    } lcd_op_e;

    // op is kept as raw bits so illegal codes 5-7 survive the queue intact
    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] data;
        logic [23:0] count;
    } lcd_req_t;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_WRLOW,
        ST_WRHIGH,
        ST_DLY
    } lcd_state_e;

    localparam int PIX_BITS = 16;

    function automatic int beats_per_pix(input int bus_w);
        return PIX_BITS / bus_w;
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Request queue: synchronous FIFO of lcd_req_t with wrap-bit pointers.
module lcd_req_fifo
    import lcd8080_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  lcd_req_t                 wdata,
    input  logic                     pop,
    output lcd_req_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    lcd_req_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // full is the registered state, so a same-cycle pop never frees a slot
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd8080_stream_ctrl.sv
// 8080 parallel write engine for ILI934x-class panels: panel reset sequencer,
// request decoder, beat FSM and registered pad drivers.
module lcd8080_stream_ctrl
    import lcd8080_pkg::*;
#(
    parameter int BUS_W        = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 1,
    parameter int RST_LOW_CYC  = 500,
    parameter int RST_WAIT_CYC = 6_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_op,
    input  logic [15:0]                   req_data,
    input  logic [23:0]                   req_count,
    output logic                          hw_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_illegal,
    output logic                          lcd_cs_n,
    output logic                          lcd_rd_n,
    output logic                          lcd_rst_n,
    output logic                          lcd_dc,
    output logic                          lcd_wr_n,
    output logic [BUS_W-1:0]              lcd_d
);

    localparam int BPP = beats_per_pix(BUS_W);

    lcd_state_e       state, state_nxt;
    lcd_req_t         req_in, head;
    logic             full, empty, pop, rdy_en;
    logic [31:0]      tmr;
    logic             tmr_done;
    logic [23:0]      pix_left;
    logic             beat_idx, beat_last, more_beats;
    logic             cur_pix, cur_dc;
    logic [15:0]      cur_data;
    logic [BUS_W-1:0] beat_word;

    assign req_in    = '{op: req_op, data: req_data, count: req_count};
    assign req_ready = rdy_en && !full;
    assign lcd_rd_n  = 1'b1;

    lcd_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && req_ready),
        .wdata (req_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign tmr_done   = (tmr == '0);
    assign beat_last  = !cur_pix || (BPP == 1) || beat_idx;
    assign more_beats = !beat_last || (pix_left > 24'd1);
    assign busy       = !(state == ST_IDLE && empty && hw_ready);

    // Narrow bus sends the high byte of a pixel first
    always_comb begin
        beat_word = '0;
        if (!cur_pix)      beat_word[7:0] = cur_data[7:0];
        else if (BPP == 1) beat_word      = cur_data[BUS_W-1:0];
        else               beat_word[7:0] = beat_idx ? cur_data[7:0] : cur_data[15:8];
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        err_illegal = 1'b0;
        case (state)
            ST_RST_LOW:  if (tmr_done) state_nxt = ST_RST_WAIT;
            ST_RST_WAIT: if (tmr_done) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    case (head.op)
                        OP_CMD, OP_DAT8, OP_PIX: state_nxt = ST_SETUP;
                        OP_FILL:  if (head.count != '0) state_nxt = ST_SETUP;
                        OP_DELAY: if (head.count != '0) state_nxt = ST_DLY;
                        default:  err_illegal = 1'b1;
                    endcase
                end
            end
            ST_SETUP:    state_nxt = ST_WRLOW;
            ST_WRLOW:    if (tmr_done) state_nxt = ST_WRHIGH;
            ST_WRHIGH:   if (tmr_done) state_nxt = more_beats ? ST_SETUP : ST_IDLE;
            ST_DLY:      if (tmr_done) state_nxt = ST_IDLE;
            default:     state_nxt = ST_RST_LOW;
        endcase
    end

    // State, shared down-timer and the latched request being played out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST_LOW;
            tmr      <= 32'(RST_LOW_CYC - 1);
            rdy_en   <= 1'b0;
            pix_left <= '0;
            beat_idx <= 1'b0;
            cur_pix  <= 1'b0;
            cur_dc   <= 1'b0;
            cur_data <= '0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_RST_WAIT: tmr <= 32'(RST_WAIT_CYC - 1);
                    ST_WRLOW:    tmr <= 32'(WR_LOW_CYC - 1);
                    ST_WRHIGH:   tmr <= 32'(WR_HIGH_CYC - 1);
                    ST_DLY:      tmr <= {8'h00, head.count} - 32'd1;
                    default:     tmr <= '0;
                endcase
            end else if (!tmr_done) begin
                tmr <= tmr - 32'd1;
            end

            if (pop) begin
                cur_data <= head.data;
                cur_dc   <= (head.op != OP_CMD);
                cur_pix  <= (head.op == OP_PIX) || (head.op == OP_FILL);
                pix_left <= (head.op == OP_FILL) ? head.count : 24'd1;
                beat_idx <= 1'b0;
            end

            if (state == ST_WRHIGH && state_nxt == ST_SETUP) begin
                if (!beat_last) begin
                    beat_idx <= 1'b1;
                end else begin
                    beat_idx <= 1'b0;
                    pix_left <= pix_left - 24'd1;
                end
            end
        end
    end

    // Pads are registered copies of the state decode, one cycle behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_ready  <= 1'b0;
            lcd_rst_n <= 1'b0;
            lcd_cs_n  <= 1'b1;
            lcd_wr_n  <= 1'b1;
            lcd_dc    <= 1'b0;
            lcd_d     <= '0;
        end else begin
            lcd_rst_n <= (state != ST_RST_LOW);
            lcd_wr_n  <= (state != ST_WRLOW);
            if (state == ST_IDLE) hw_ready <= 1'b1;
            if (state == ST_SETUP) begin
                lcd_d    <= beat_word;
                lcd_dc   <= cur_dc;
                lcd_cs_n <= 1'b0;
            end else if (state == ST_IDLE && empty) begin
                lcd_cs_n <= 1'b1;
            end
        end
    end

endmodule
